// File: rtl/instr_fetch_unit.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Reads the program counter, issues a single-beat instruction memory read and
// presents the fetched word to decode over a valid/ready handshake. After every
// completed fetch it writes PC+PC_STEP back through the PC register's
// instruction write port. Decode redirects arrive as a flush pulse in the same
// cycle that decode writes the new PC.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous, active-high reset
//   start        level; enables continuous fetching
//   flush        decode redirect pulse
//   pc_rdata     current PC from the PC register
//   pc_wdata     PC write-back value
//   pc_wren      PC write-back strobe
//   mem_req      one-cycle read request
//   mem_addr     read address, stable from request until response consumed
//   mem_ack      read response valid
//   mem_rdata    read data, valid with mem_ack
//   instr_valid  fetched instruction available to decode
//   instr_data   fetched instruction word
//   instr_pc     address the instruction was fetched from
//   instr_ready  decode accepts the instruction
//   busy         high in any state other than IDLE or FAULT
//   fault        sticky memory-timeout flag
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
   parameter logic [31:0] PC_STEP = 32'd4,
   parameter int unsigned TIMEOUT = 255   // legal range 1..65535
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        flush,
   input  logic [31:0] pc_rdata,
   output logic [31:0] pc_wdata,
   output logic        pc_wren,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic        instr_valid,
   output logic [31:0] instr_data,
   output logic [31:0] instr_pc,
   input  logic        instr_ready,
   output logic        busy,
   output logic        fault
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_REQ   = 3'd1;
   localparam logic [2:0] S_WAIT  = 3'd2;
   localparam logic [2:0] S_HOLD  = 3'd3;
   localparam logic [2:0] S_DRAIN = 3'd4;
   localparam logic [2:0] S_FAULT = 3'd5;

   // Last timer value before a missing ack is declared a fault: the timer is
   // 0 in the first WAIT cycle, so TIMEOUT waiting cycles end at TIMEOUT-1.
   localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT - 1);

   logic [2:0]  state_q;
   logic [2:0]  state_d;
   logic [15:0] timer_q;
   logic [31:0] addr_q;
   logic [31:0] data_q;
   logic [31:0] wdata_q;
   logic        wren_q;
   logic        timed_out;

   assign timed_out = (timer_q == TIMER_LAST);

   // NOTE: state_d is given its current value before the case so that every
   // path assigns it; a missing default would infer a latch.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = S_REQ;
         // The request has already gone out, so a redirect here still has to
         // swallow the ack that will come back for it.
         S_REQ:   state_d = flush ? S_DRAIN : S_WAIT;
         S_WAIT: begin
            if (mem_ack)        state_d = flush ? S_REQ : S_HOLD;
            else if (timed_out) state_d = S_FAULT;
            else if (flush)     state_d = S_DRAIN;
         end
         S_HOLD:  if (flush || instr_ready) state_d = start ? S_REQ : S_IDLE;
         S_DRAIN: begin
            if (mem_ack)        state_d = start ? S_REQ : S_IDLE;
            else if (timed_out) state_d = S_FAULT;
         end
         S_FAULT: state_d = S_FAULT;
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: all state here uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         timer_q <= '0;
         addr_q  <= '0;
         data_q  <= '0;
         wdata_q <= '0;
         wren_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         // The write-back strobe and its data live for exactly one cycle.
         wren_q  <= 1'b0;
         wdata_q <= '0;
         case (state_q)
            S_REQ: begin
               addr_q  <= pc_rdata;
               timer_q <= '0;
            end
            S_WAIT, S_DRAIN: begin
               if (!mem_ack) timer_q <= timer_q + 16'd1;
               if ((state_q == S_WAIT) && mem_ack && !flush) begin
                  data_q  <= mem_rdata;
                  wren_q  <= 1'b1;
                  wdata_q <= addr_q + PC_STEP;   // wraps modulo 2^32
               end
            end
            default: ;
         endcase
      end
   end

   // In REQ the address comes straight from the PC register so that a PC
   // written at the preceding edge (own write-back or decode redirect) is the
   // one fetched. Afterwards the latched copy holds it stable.
   always_comb begin
      mem_addr = '0;
      case (state_q)
         S_REQ:           mem_addr = pc_rdata;
         S_WAIT, S_DRAIN: mem_addr = addr_q;
         default:         mem_addr = '0;
      endcase
   end

   assign mem_req     = (state_q == S_REQ);
   assign instr_valid = (state_q == S_HOLD);
   assign instr_data  = instr_valid ? data_q : '0;
   assign instr_pc    = instr_valid ? addr_q : '0;
   assign pc_wdata    = wdata_q;
   // The PC register lets an instr write win over a decode write, so a
   // concurrent redirect must mask our write-back or the redirect is lost.
   assign pc_wren     = wren_q & ~flush;
   assign busy        = (state_q != S_IDLE) && (state_q != S_FAULT);
   assign fault       = (state_q == S_FAULT);

endmodule

// File: tb/tb_instr_fetch_unit.sv
`timescale 1ns/1ps
module tb_instr_fetch_unit;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] data;
   } instr_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        flush;
   logic [31:0] pc_rdata;
   logic [31:0] pc_wdata;
   logic        pc_wren;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        instr_valid;
   logic [31:0] instr_data;
   logic [31:0] instr_pc;
   logic        instr_ready;
   logic        busy;
   logic        fault;

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;
   int last_req_cyc = 0;
   int req_gap = 0;

   logic [31:0] exp_req[$];
   logic [31:0] exp_wr[$];
   instr_t      exp_instr[$];

   // PC register model: instr write has priority over decode write.
   logic        dec_wr;
   logic [31:0] dec_data;
   logic [31:0] pc_model;

   // Memory model with programmable latency (cycles from request to ack).
   logic        mem_en;
   int          mem_lat;
   logic        mdl_ack = 1'b0;
   logic [31:0] mdl_rdata = '0;
   logic        mdl_pend = 1'b0;
   int          mdl_cd = 0;
   logic [31:0] mdl_paddr = '0;
   logic        man_ack;
   logic [31:0] man_rdata;

   instr_fetch_unit #(.PC_STEP(32'd4), .TIMEOUT(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .flush       (flush),
      .pc_rdata    (pc_rdata),
      .pc_wdata    (pc_wdata),
      .pc_wren     (pc_wren),
      .mem_req     (mem_req),
      .mem_addr    (mem_addr),
      .mem_ack     (mem_ack),
      .mem_rdata   (mem_rdata),
      .instr_valid (instr_valid),
      .instr_data  (instr_data),
      .instr_pc    (instr_pc),
      .instr_ready (instr_ready),
      .busy        (busy),
      .fault       (fault)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h0000_0100) return 32'hDEAD_BEEF;
      return a ^ 32'h5A5A_C3C3;
   endfunction

   always @(posedge clk) begin
      if (pc_wren)     pc_model <= pc_wdata;
      else if (dec_wr) pc_model <= dec_data;
   end
   assign pc_rdata = pc_model;

   always @(posedge clk) begin
      mdl_ack <= 1'b0;
      if (mem_en && mem_req) begin
         if (mem_lat <= 1) begin
            mdl_ack   <= 1'b1;
            mdl_rdata <= mem_word(mem_addr);
            mdl_pend  <= 1'b0;
         end else begin
            mdl_pend  <= 1'b1;
            mdl_cd    <= mem_lat - 1;
            mdl_paddr <= mem_addr;
         end
      end else if (mdl_pend) begin
         if (mdl_cd <= 1) begin
            mdl_ack   <= 1'b1;
            mdl_rdata <= mem_word(mdl_paddr);
            mdl_pend  <= 1'b0;
         end else begin
            mdl_cd <= mdl_cd - 1;
         end
      end
   end
   assign mem_ack   = mdl_ack | man_ack;
   assign mem_rdata = man_ack ? man_rdata : mdl_rdata;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Scoreboard monitors, sampled on the falling edge.
   always @(negedge clk) begin
      if (!rst) begin
         if (mem_req) begin
            req_gap      = cyc - last_req_cyc;
            last_req_cyc = cyc;
            check("mem_req_expected", 32'(exp_req.size() > 0), 32'd1);
            if (exp_req.size() > 0) check("mem_addr", mem_addr, exp_req.pop_front());
         end
         if (pc_wren) begin
            check("pc_wren_expected", 32'(exp_wr.size() > 0), 32'd1);
            if (exp_wr.size() > 0) check("pc_wdata", pc_wdata, exp_wr.pop_front());
         end
         if (instr_valid && instr_ready) begin
            check("instr_expected", 32'(exp_instr.size() > 0), 32'd1);
            if (exp_instr.size() > 0) begin
               instr_t e;
               e = exp_instr.pop_front();
               check("instr_pc", instr_pc, e.pc);
               check("instr_data", instr_data, e.data);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: bench did not reach its summary");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1; start = 1'b0; flush = 1'b0; instr_ready = 1'b1;
      dec_wr = 1'b0; dec_data = '0; pc_model = '0;
      mem_en = 1'b1; mem_lat = 1; man_ack = 1'b0; man_rdata = '0;
      step(2);

      // Reset state
      check("rst_mem_req", 32'(mem_req), 32'd0);
      check("rst_mem_addr", mem_addr, 32'd0);
      check("rst_pc_wren", 32'(pc_wren), 32'd0);
      check("rst_pc_wdata", pc_wdata, 32'd0);
      check("rst_instr_valid", 32'(instr_valid), 32'd0);
      check("rst_instr_data", instr_data, 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_fault", 32'(fault), 32'd0);

      dec_wr = 1'b1; dec_data = 32'h100;
      step(1);
      dec_wr = 1'b0; rst = 1'b0;
      step(1);

      // Basic fetch, 3-cycle cadence
      exp_req.push_back(32'h100);
      exp_req.push_back(32'h104);
      exp_instr.push_back('{32'h100, 32'hDEAD_BEEF});
      exp_instr.push_back('{32'h104, mem_word(32'h104)});
      exp_wr.push_back(32'h104);
      exp_wr.push_back(32'h108);
      start = 1'b1;
      step(4);
      start = 1'b0;
      step(1);
      check("cadence", 32'(req_gap), 32'd3);
      step(2);
      check("basic_idle_busy", 32'(busy), 32'd0);

      // Backpressure: decode holds off for 5 cycles
      exp_req.push_back(32'h108);
      exp_instr.push_back('{32'h108, mem_word(32'h108)});
      exp_wr.push_back(32'h10C);
      instr_ready = 1'b0; start = 1'b1;
      step(1);
      start = 1'b0;
      step(2);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_valid", 32'(instr_valid), 32'd1);
         check("bp_data", instr_data, mem_word(32'h108));
         check("bp_pc", instr_pc, 32'h108);
         check("bp_no_req", 32'(mem_req), 32'd0);
         step(1);
      end
      instr_ready = 1'b1;
      step(1);
      check("bp_idle_busy", 32'(busy), 32'd0);

      // Flush while waiting for the ack, decode redirects to 0x200
      exp_req.push_back(32'h10C);
      exp_req.push_back(32'h200);
      exp_instr.push_back('{32'h200, mem_word(32'h200)});
      exp_wr.push_back(32'h204);
      mem_lat = 3; start = 1'b1;
      step(2);
      flush = 1'b1; dec_wr = 1'b1; dec_data = 32'h200;
      step(1);
      flush = 1'b0; dec_wr = 1'b0; mem_lat = 1;
      check("drain_busy", 32'(busy), 32'd1);
      check("drain_valid", 32'(instr_valid), 32'd0);
      check("drain_addr_held", mem_addr, 32'h10C);
      step(2);
      start = 1'b0;
      step(3);
      check("wflush_idle_busy", 32'(busy), 32'd0);

      // Flush colliding with the write-back in the first HOLD cycle
      exp_req.push_back(32'h204);
      exp_req.push_back(32'h300);
      exp_instr.push_back('{32'h300, mem_word(32'h300)});
      exp_wr.push_back(32'h304);
      start = 1'b1;
      step(3);
      flush = 1'b1; dec_wr = 1'b1; dec_data = 32'h300; instr_ready = 1'b0;
      @(negedge clk);
      check("hflush_wren_masked", 32'(pc_wren), 32'd0);
      check("hflush_valid", 32'(instr_valid), 32'd1);
      step(1);
      flush = 1'b0; dec_wr = 1'b0; instr_ready = 1'b1; start = 1'b0;
      @(negedge clk);
      check("hflush_valid_drop", 32'(instr_valid), 32'd0);
      check("hflush_refetch", 32'(mem_req), 32'd1);
      step(3);
      check("hflush_idle_busy", 32'(busy), 32'd0);

      // PC wrap, then asynchronous reset in the middle of WAIT
      exp_req.push_back(32'hFFFF_FFFC);
      exp_req.push_back(32'h0000_0000);
      exp_instr.push_back('{32'hFFFF_FFFC, mem_word(32'hFFFF_FFFC)});
      exp_wr.push_back(32'h0000_0000);
      dec_wr = 1'b1; dec_data = 32'hFFFF_FFFC;
      step(1);
      dec_wr = 1'b0; start = 1'b1;
      step(2);
      mem_lat = 3;
      step(4);
      check("pre_rst_busy", 32'(busy), 32'd1);
      #2 rst = 1'b1;
      #1;
      check("async_rst_busy", 32'(busy), 32'd0);
      check("async_rst_req", 32'(mem_req), 32'd0);
      check("async_rst_valid", 32'(instr_valid), 32'd0);
      check("async_rst_wren", 32'(pc_wren), 32'd0);
      rst = 1'b0; start = 1'b0; mem_lat = 1;
      step(1);
      check("late_ack_seen", 32'(mem_ack), 32'd1);
      check("late_ack_busy", 32'(busy), 32'd0);
      step(1);
      check("late_ack_valid", 32'(instr_valid), 32'd0);
      check("late_ack_idle", 32'(busy), 32'd0);

      // Timeout with TIMEOUT=4, sticky fault
      exp_req.push_back(32'h400);
      mem_en = 1'b0; dec_wr = 1'b1; dec_data = 32'h400;
      step(1);
      dec_wr = 1'b0; start = 1'b1;
      step(5);
      check("to_before_fault", 32'(fault), 32'd0);
      check("to_addr_held", mem_addr, 32'h400);
      step(1);
      check("to_fault", 32'(fault), 32'd1);
      check("to_fault_busy", 32'(busy), 32'd0);
      check("to_fault_addr", mem_addr, 32'd0);
      man_ack = 1'b1; man_rdata = 32'h1234_5678;
      step(1);
      man_ack = 1'b0;
      check("to_sticky", 32'(fault), 32'd1);
      check("to_ack_ignored", 32'(instr_valid), 32'd0);
      check("to_ack_data", instr_data, 32'd0);
      #2 rst = 1'b1;
      #1;
      check("to_rst_clears", 32'(fault), 32'd0);
      rst = 1'b0; start = 1'b0; mem_en = 1'b1;
      step(2);
      check("to_after_rst", 32'(busy), 32'd0);

      check("req_queue_drained", 32'(exp_req.size()), 32'd0);
      check("wr_queue_drained", 32'(exp_wr.size()), 32'd0);
      check("instr_queue_drained", 32'(exp_instr.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
